// File: rtl/srrc_pkg.sv
// Shared constants for the folded 17-tap SRRC sequencer: tap counts, the
// default coefficient half-set, FSM encoding and the output saturation helper.
package srrc_pkg;

  localparam int NUM_TAPS = 17;
  localparam int NUM_UNIQ = 9;
  localparam int SRRC_CW  = 18;

  typedef logic signed [SRRC_CW-1:0] coef_t;

  // Outer taps first; entry 8 is the centre tap.
  localparam coef_t SRRC_B [NUM_UNIQ] = '{
    18'sd314, -18'sd2115, -18'sd5743, -18'sd6936, -18'sd719,
    18'sd15367, 18'sd37897, 18'sd57966, 18'sd66023
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/srrc_mac.sv
// Shared pre-add / multiply / accumulate datapath for the folded SRRC filter.
// acc presents the running sum including the term selected this cycle.
module srrc_mac #(
  parameter int DW = 18,
  parameter int CW = 18,
  parameter int AW = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b_sym,
  input  logic signed [CW-1:0] coef,
  output logic signed [AW-1:0] acc
);

  logic signed [DW:0]      pre_sum;
  logic signed [DW+CW:0]   pre_ext;
  logic signed [DW+CW:0]   coef_ext;
  logic signed [DW+CW:0]   prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    acc_q;
  logic signed [AW-1:0]    acc_d;

  always_comb begin
    pre_sum  = {a[DW-1], a} + {b_sym[DW-1], b_sym};
    pre_ext  = {{CW{pre_sum[DW]}}, pre_sum};
    coef_ext = {{(DW+1){coef[CW-1]}}, coef};
    prod     = pre_ext * coef_ext;
    prod_ext = {{(AW-DW-CW-1){prod[DW+CW]}}, prod};
    acc      = en ? (acc_q + prod_ext) : acc_q;
    acc_d    = clr ? '0 : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/srrc_mac_sched.sv
// Folded 17-tap symmetric SRRC filter sequencer: one MAC walks the 9 unique
// coefficients per accepted sample. Optional runtime coefficient writes via SRRC_COEF_WR_EN.
module srrc_mac_sched
  import srrc_pkg::*;
#(
  parameter int DW   = 18,
  parameter int CW   = 18,
  parameter int AW   = 40,
  parameter int FRAC = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
`ifdef SRRC_COEF_WR_EN
  input  logic          coef_wr_en,
  input  logic [3:0]    coef_wr_addr,
  input  logic [CW-1:0] coef_wr_data,
`endif
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  state_e                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic signed [DW-1:0]  x_q [NUM_TAPS];
  logic signed [DW-1:0]  x_d [NUM_TAPS];
  logic signed [DW-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  mac_clr;
  logic                  mac_en;
  logic signed [DW-1:0]  mac_a;
  logic signed [DW-1:0]  mac_b;
  logic signed [CW-1:0]  coef_sel;
  logic signed [AW-1:0]  mac_acc;
  logic [4:0]            idx5;
  logic [4:0]            mirror_idx;
  logic signed [63:0]    acc_wide;
  logic signed [63:0]    acc_shr;
  logic signed [DW-1:0]  sat_out;

`ifdef SRRC_COEF_WR_EN
  logic signed [CW-1:0]  coef_q [NUM_UNIQ];
  logic signed [CW-1:0]  coef_d [NUM_UNIQ];

  // Coefficients only change between samples so a result never mixes two sets.
  always_comb begin
    coef_d = coef_q;
    if (coef_wr_en && (state_q == IDLE) && (coef_wr_addr < 4'(NUM_UNIQ))) begin
      coef_d[coef_wr_addr] = $signed(coef_wr_data);
    end
  end

  assign coef_sel = coef_q[idx_q];
`else
  assign coef_sel = SRRC_B[idx_q];
`endif

  // Operand select: tap idx pairs with its mirror; the centre tap has no partner.
  always_comb begin
    idx5       = {1'b0, idx_q};
    mirror_idx = 5'd16 - idx5;
    mac_a      = x_q[idx5];
    mac_b      = (idx_q == 4'd8) ? '0 : x_q[mirror_idx];
  end

  srrc_mac #(
    .DW (DW),
    .CW (CW),
    .AW (AW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (mac_a),
    .b_sym (mac_b),
    .coef  (coef_sel),
    .acc   (mac_acc)
  );

  // Output scaling: floor by FRAC then clamp to the DW-bit sample range.
  always_comb begin
    acc_wide = {{(64-AW){mac_acc[AW-1]}}, mac_acc};
    acc_shr  = acc_wide >>> FRAC;
    sat_out  = DW'(sat_to_width(acc_shr, DW));
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d[0] = $signed(in_data);
          for (int k = 1; k < NUM_TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          mac_clr = 1'b1;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        mac_en = 1'b1;
        if (idx_q == 4'(NUM_UNIQ - 1)) begin
          out_data_d  = sat_out;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
      end
`ifdef SRRC_COEF_WR_EN
      coef_q <= SRRC_B;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
`ifdef SRRC_COEF_WR_EN
      coef_q <= coef_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_srrc_mac_sched.sv
// Self-checking bench for srrc_mac_sched: direct-form 17-tap reference model
// feeding a scoreboard queue, plus fixed expectations for impulse, DC and timing.
`timescale 1ns/1ps
module tb_srrc_mac_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef SRRC_COEF_WR_EN
  logic        coef_wr_en;
  logic [3:0]  coef_wr_addr;
  logic [17:0] coef_wr_data;
`endif

  srrc_mac_sched dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
`ifdef SRRC_COEF_WR_EN
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
`endif
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int coef_def [9] = '{314, -2115, -5743, -6936, -719, 15367, 37897, 57966, 66023};
  int coef_m   [9];
  int imp_tab  [17] = '{157, -1058, -2872, -3468, -360, 7683, 18948, 28983, 33011,
                        28983, 18948, 7683, -360, -3468, -2872, -1058, 157};
  longint mdl [17];

  int stim_q[$];
  int exp_q[$];
  int got_q[$];
  int acc_cyc_q[$];
  int out_cyc_q[$];

  function automatic int model_push(input int s);
    longint sum;
    for (int k = 16; k > 0; k--) mdl[k] = mdl[k-1];
    mdl[0] = longint'(s);
    sum = 0;
    for (int k = 0; k < 17; k++) begin
      sum += mdl[k] * longint'(coef_m[(k <= 8) ? k : (16 - k)]);
    end
    sum = sum >>> 17;
    if (sum > 131071) sum = 131071;
    if (sum < -131072) sum = -131072;
    return int'(sum);
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 17; k++) mdl[k] = 0;
    coef_m = coef_def;
    stim_q.delete();
    exp_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef SRRC_COEF_WR_EN
    coef_wr_en = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
  endtask

  // Streams stim_q with in_valid held high; collects outputs and handshake cycles.
  task automatic run_stream(input int budget);
    int  t0;
    int  target;
    bit  hs;
    t0     = cyc;
    target = got_q.size() + stim_q.size();
    while (got_q.size() < target && (cyc - t0) < budget) begin
      in_valid  = (stim_q.size() > 0);
      in_data   = in_valid ? 18'(stim_q[0]) : '0;
      out_ready = 1'b1;
      hs        = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model_push(stim_q[0]));
        acc_cyc_q.push_back(cyc);
        hs = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(int'($signed(out_data)));
        out_cyc_q.push_back(cyc);
      end
      @(posedge clk); #1;
      if (hs) void'(stim_q.pop_front());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 18'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_impulse();
    int g;
    int e;
    do_reset();
    stim_q.push_back(65536);
    repeat (19) stim_q.push_back(0);
    run_stream(600);
    checks++;
    if (got_q.size() !== 20) begin errors++; $display("FAIL impulse_count: got %0d outputs expected 20", got_q.size()); end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL impulse_sb[%0d]: got %0d expected %0d", i, g, e); end
      checks++;
      if (g !== ((i < 17) ? imp_tab[i] : 0)) begin
        errors++; $display("FAIL impulse_tab[%0d]: got %0d expected %0d", i, g, (i < 17) ? imp_tab[i] : 0);
      end
    end
  endtask

  task automatic test_dc_max();
    int g;
    int e;
    int lvl [2] = '{131071, -131072};
    for (int p = 0; p < 2; p++) begin
      do_reset();
      repeat (20) stim_q.push_back(lvl[p]);
      run_stream(600);
      checks++;
      if (got_q.size() !== 20) begin errors++; $display("FAIL dc_count[%0d]: got %0d outputs expected 20", p, got_q.size()); end
      for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (g !== e) begin errors++; $display("FAIL dc_sb[%0d][%0d]: got %0d expected %0d", p, i, g, e); end
        if (i >= 8) begin
          checks++;
          if (g !== lvl[p]) begin errors++; $display("FAIL dc_sat[%0d][%0d]: got %0d expected %0d", p, i, g, lvl[p]); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          w;
    int          e;
    logic [17:0] d0;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 18'd5000;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: in_ready=%b expected 1", in_ready); end
    exp_q.push_back(model_push(5000));
    @(posedge clk); #1;
    in_data = 18'd777;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 30) begin @(negedge clk); w++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_wait: out_valid=%b expected 1 within 30 cycles", out_valid); end
    d0 = out_data;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall: out_valid=%b out_data=%0d in_ready=%b expected 1/%0d/0", out_valid, out_data, in_ready, d0);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) !== e) begin
      errors++; $display("FAIL bp_release: out_valid=%b out_data=%0d expected 1/%0d", out_valid, $signed(out_data), e);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_idle: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_latency();
    int g;
    int e;
    do_reset();
    for (int i = 1; i <= 5; i++) stim_q.push_back(i * 1000);
    run_stream(200);
    checks++;
    if (got_q.size() !== 5 || acc_cyc_q.size() !== 5 || out_cyc_q.size() !== 5) begin
      errors++; $display("FAIL lat_count: outputs=%0d accepts=%0d expected 5/5", got_q.size(), acc_cyc_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (out_cyc_q[i] - acc_cyc_q[i] !== 10) begin
          errors++; $display("FAIL lat_out[%0d]: got %0d cycles expected 10", i, out_cyc_q[i] - acc_cyc_q[i]);
        end
        if (i > 0) begin
          checks++;
          if (acc_cyc_q[i] - acc_cyc_q[i-1] !== 11) begin
            errors++; $display("FAIL lat_accept[%0d]: spacing %0d expected 11", i, acc_cyc_q[i] - acc_cyc_q[i-1]);
          end
        end
        g = got_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (g !== e) begin errors++; $display("FAIL lat_sb[%0d]: got %0d expected %0d", i, g, e); end
      end
    end
  endtask

  task automatic test_reset_mid_accum();
    int g;
    do_reset();
    stim_q.push_back(65536);
    run_stream(100);
    g = (got_q.size() > 0) ? got_q.pop_front() : -1;
    checks++;
    if (g !== 157) begin errors++; $display("FAIL rst_pre_out: got %0d expected 157", g); end
    in_valid = 1'b1;
    in_data  = 18'd1000;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_accept: in_ready=%b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (in_ready !== 1'b0 || int'($signed(out_data)) !== 157) begin
      errors++; $display("FAIL rst_mid_state: in_ready=%b out_data=%0d expected 0/157", in_ready, $signed(out_data));
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 18'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async: out_valid=%b out_data=%0d in_ready=%b expected 0/0/1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
    stim_q.push_back(65536);
    repeat (16) stim_q.push_back(0);
    run_stream(600);
    checks++;
    if (got_q.size() !== 17) begin errors++; $display("FAIL rst_imp_count: got %0d outputs expected 17", got_q.size()); end
    for (int i = 0; got_q.size() > 0 && i < 17; i++) begin
      g = got_q.pop_front();
      checks++;
      if (g !== imp_tab[i]) begin errors++; $display("FAIL rst_imp[%0d]: got %0d expected %0d", i, g, imp_tab[i]); end
    end
  endtask

`ifdef SRRC_COEF_WR_EN
  task automatic test_coef_wr();
    int g;
    int e;
    int w;
    do_reset();
    @(posedge clk); #1;
    coef_wr_en   = 1'b1;
    coef_wr_addr = 4'd8;
    coef_wr_data = 18'd0;
    @(posedge clk); #1;
    coef_wr_addr = 4'd12;
    coef_wr_data = 18'd9999;
    @(posedge clk); #1;
    coef_wr_en = 1'b0;
    coef_m[8]  = 0;
    stim_q.push_back(65536);
    repeat (16) stim_q.push_back(0);
    run_stream(600);
    checks++;
    if (got_q.size() !== 17) begin errors++; $display("FAIL cw_count: got %0d outputs expected 17", got_q.size()); end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL cw_sb[%0d]: got %0d expected %0d", i, g, e); end
      if (i == 8) begin
        checks++;
        if (g !== 0) begin errors++; $display("FAIL cw_centre: got %0d expected 0", g); end
      end
    end
    stim_q.push_back(65536);
    fork
      run_stream(100);
      begin
        w = 0;
        @(negedge clk);
        while (in_ready && w < 20) begin @(negedge clk); w++; end
        coef_wr_en   = 1'b1;
        coef_wr_addr = 4'd0;
        coef_wr_data = 18'd0;
        @(negedge clk);
        coef_wr_en = 1'b0;
      end
    join
    stim_q.push_back(65536);
    run_stream(100);
    checks++;
    if (got_q.size() !== 2) begin errors++; $display("FAIL cw_accum_count: got %0d outputs expected 2", got_q.size()); end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL cw_accum_sb[%0d]: got %0d expected %0d", i, g, e); end
    end
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef SRRC_COEF_WR_EN
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
`endif
    clear_model();
    test_reset();
    test_impulse();
    test_dc_max();
    test_backpressure();
    test_latency();
    test_reset_mid_accum();
`ifdef SRRC_COEF_WR_EN
    test_coef_wr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
